// File: rtl/vga_timing_if.sv
// Raster bus between the VGA timing generator and the screen-control stage.
// master: timing generator (takes en, drives counters/flags).
// slave : raster consumer (drives en, reads counters/flags).
interface vga_timing_if;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned FC_W  = 16;

  logic             en;
  logic [CNT_W-1:0] hcount_out;
  logic [CNT_W-1:0] vcount_out;
  logic             hblnk_out;
  logic             vblnk_out;
  logic             hsync_out;
  logic             vsync_out;
  logic             frame_tick;
  logic [FC_W-1:0]  frame_cnt;

  modport master (
    input  en,
    output hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_tick, frame_cnt
  );

  modport slave (
    output en,
    input  hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_tick, frame_cnt
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (default 1024x768 @ 60 Hz).
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-low reset
//   bus  - vga_timing_if.master: en in; hcount/vcount, blank, sync,
//          frame_tick and frame_cnt out, all registered.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master bus
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned FC_W    = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 11 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("vga_timing: H_TOTAL and V_TOTAL must each be <= 2048");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLK_FRST = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_BLK_FRST = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_IDLE  = ~SYNC_POL;

  logic [CNT_W-1:0] hcount_q;
  logic [CNT_W-1:0] vcount_q;
  logic             hblnk_q;
  logic             vblnk_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_tick_q;
  logic [FC_W-1:0]  frame_cnt_q;

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             wrap_c;

  // Next raster position; holds when en is low, wrap_c flags (last,last)->(0,0).
  always_comb begin
    h_nxt  = hcount_q;
    v_nxt  = vcount_q;
    wrap_c = 1'b0;
    if (bus.en) begin
      if (hcount_q == H_LAST) begin
        h_nxt = '0;
        if (vcount_q == V_LAST) begin
          v_nxt  = '0;
          wrap_c = 1'b1;
        end else begin
          v_nxt = vcount_q + CNT_W'(1);
        end
      end else begin
        h_nxt = hcount_q + CNT_W'(1);
      end
    end
  end

  // Flags decode the next position so counts and flags stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      hcount_q     <= h_nxt;
      vcount_q     <= v_nxt;
      hblnk_q      <= (h_nxt >= H_BLK_FRST);
      vblnk_q      <= (v_nxt >= V_BLK_FRST);
      hsync_q      <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_POL : SYNC_IDLE;
      vsync_q      <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_POL : SYNC_IDLE;
      frame_tick_q <= wrap_c;
      frame_cnt_q  <= frame_cnt_q + FC_W'(wrap_c);
    end
  end

  assign bus.hcount_out = hcount_q;
  assign bus.vcount_out = vcount_q;
  assign bus.hblnk_out  = hblnk_q;
  assign bus.vblnk_out  = vblnk_q;
  assign bus.hsync_out  = hsync_q;
  assign bus.vsync_out  = vsync_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
